// File: rtl/boot_sleep_pkg.sv
// Shared definitions for the boot/sleep controller and the peripheral status register.
// The state encoding is visible to software through state_o.
package boot_sleep_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_RST_HOLD   = 3'd1,
        ST_WAIT_FETCH = 3'd2,
        ST_RUN        = 3'd3,
        ST_SLEEP_PEND = 3'd4,
        ST_SLEEP      = 3'd5,
        ST_WAKE       = 3'd6
    } state_t;

    localparam logic [2:0] STATE_ENC_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] STATE_ENC_RST_HOLD   = 3'd1;
    localparam logic [2:0] STATE_ENC_WAIT_FETCH = 3'd2;
    localparam logic [2:0] STATE_ENC_RUN        = 3'd3;
    localparam logic [2:0] STATE_ENC_SLEEP_PEND = 3'd4;
    localparam logic [2:0] STATE_ENC_SLEEP      = 3'd5;
    localparam logic [2:0] STATE_ENC_WAKE       = 3'd6;

    // Cycles the core clock runs with fetch held off after a wake-up.
    localparam int unsigned WAKE_CYCLES = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/boot_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Clear has priority over enable; the count holds once it equals i_terminal.
module boot_sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_terminal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == i_terminal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = w_tc;

endmodule

// File: rtl/boot_sleep_ctrl.sv
// Power-up sequencing (FLL lock, core reset hold, boot address latch) and
// software-requested clock-gated sleep with interrupt wake for the core region.
module boot_sleep_ctrl
    import boot_sleep_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned RST_HOLD_CYCLES     = 8,
    parameter logic [31:0] BOOT_ADDR_ROM       = 32'h0000_8000,
    parameter logic [31:0] BOOT_ADDR_RAM       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fll_lock_i,
    input  logic        boot_sel_i,
    input  logic        fetch_enable_i,
    input  logic        sleep_req_i,
    input  logic        core_busy_i,
    input  logic        irq_pending_i,
    output logic        core_rst_o,
    output logic        fetch_enable_o,
    output logic        clk_gate_core_o,
    output logic [31:0] boot_addr_o,
    output logic        lock_timeout_o,
    output logic [2:0]  state_o
);

    localparam int unsigned STAB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TO_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned HOLD_N = (RST_HOLD_CYCLES > WAKE_CYCLES) ? RST_HOLD_CYCLES : WAKE_CYCLES;
    localparam int unsigned HOLD_W = cnt_width(HOLD_N);

    state_t            r_state;
    state_t            w_next;
    logic              w_set_timeout;
    logic              w_latch_boot;

    logic              r_core_rst;
    logic              r_fetch_en;
    logic              r_clk_gate;
    logic [31:0]       r_boot_addr;
    logic              r_lock_timeout;

    logic              w_stab_clr;
    logic              w_stab_tc;
    logic [STAB_W-1:0] w_stab_cnt;
    logic              w_to_clr;
    logic              w_to_tc;
    logic [TO_W-1:0]   w_to_cnt;
    logic              w_hold_clr;
    logic              w_hold_tc;
    logic [HOLD_W-1:0] w_hold_cnt;
    logic [HOLD_W-1:0] w_hold_term;
    logic              w_in_hold;

    assign w_stab_clr = (r_state != ST_WAIT_LOCK) || !fll_lock_i;
    assign w_to_clr   = (r_state != ST_WAIT_LOCK);

    // One counter times both RST_HOLD and WAKE; it restarts on every state change.
    assign w_in_hold   = (r_state == ST_RST_HOLD) || (r_state == ST_WAKE);
    assign w_hold_clr  = !w_in_hold || (w_next != r_state);
    assign w_hold_term = (r_state == ST_WAKE) ? HOLD_W'(WAKE_CYCLES - 1)
                                              : HOLD_W'(RST_HOLD_CYCLES - 1);

    boot_sat_counter #(.WIDTH(STAB_W)) u_stab_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_stab_clr),
        .i_en       (fll_lock_i),
        .i_terminal (STAB_W'(LOCK_STABLE_CYCLES - 1)),
        .o_count    (w_stab_cnt),
        .o_tc       (w_stab_tc)
    );

    boot_sat_counter #(.WIDTH(TO_W)) u_to_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_to_clr),
        .i_en       (1'b1),
        .i_terminal (TO_W'(LOCK_TIMEOUT_CYCLES - 1)),
        .o_count    (w_to_cnt),
        .o_tc       (w_to_tc)
    );

    boot_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_hold_clr),
        .i_en       (1'b1),
        .i_terminal (w_hold_term),
        .o_count    (w_hold_cnt),
        .o_tc       (w_hold_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_timeout = 1'b0;
        w_latch_boot  = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                // A completed lock run beats a coincident timeout.
                if (fll_lock_i && w_stab_tc) begin
                    w_next = ST_RST_HOLD;
                end else if (w_to_tc) begin
                    w_next        = ST_RST_HOLD;
                    w_set_timeout = 1'b1;
                end
            end
            ST_RST_HOLD: begin
                if (w_hold_tc) begin
                    w_next       = ST_WAIT_FETCH;
                    w_latch_boot = 1'b1;
                end
            end
            ST_WAIT_FETCH: begin
                if (fetch_enable_i) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!fetch_enable_i) begin
                    w_next = ST_WAIT_FETCH;
                end else if (sleep_req_i) begin
                    w_next = ST_SLEEP_PEND;
                end
            end
            ST_SLEEP_PEND: begin
                if (irq_pending_i) begin
                    w_next = ST_RUN;
                end else if (!core_busy_i) begin
                    w_next = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (irq_pending_i) begin
                    w_next = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (w_hold_tc) begin
                    w_next = fetch_enable_i ? ST_RUN : ST_WAIT_FETCH;
                end
            end
            default: begin
                w_next = ST_WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered from the next state so they move on the transition edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_rst     <= 1'b1;
            r_fetch_en     <= 1'b0;
            r_clk_gate     <= 1'b1;
            r_boot_addr    <= BOOT_ADDR_RAM;
            r_lock_timeout <= 1'b0;
        end else begin
            r_core_rst <= (w_next == ST_WAIT_LOCK) || (w_next == ST_RST_HOLD);
            r_fetch_en <= (w_next == ST_RUN);
            r_clk_gate <= (w_next != ST_SLEEP);
            if (w_set_timeout) begin
                r_lock_timeout <= 1'b1;
            end
            if (w_latch_boot) begin
                r_boot_addr <= boot_sel_i ? BOOT_ADDR_ROM : BOOT_ADDR_RAM;
            end
        end
    end

    assign core_rst_o      = r_core_rst;
    assign fetch_enable_o  = r_fetch_en;
    assign clk_gate_core_o = r_clk_gate;
    assign boot_addr_o     = r_boot_addr;
    assign lock_timeout_o  = r_lock_timeout;
    assign state_o         = r_state;

endmodule

// File: tb/tb_boot_sleep_ctrl.sv
// Directed bench for boot_sleep_ctrl: lock timeout, normal boot, sleep/wake,
// priority corner cases and asynchronous reset while sleeping.
module tb_boot_sleep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fll_lock_i = 1'b0;
    logic        boot_sel_i = 1'b0;
    logic        fetch_enable_i = 1'b0;
    logic        sleep_req_i = 1'b0;
    logic        core_busy_i = 1'b0;
    logic        irq_pending_i = 1'b0;
    logic        core_rst_o;
    logic        fetch_enable_o;
    logic        clk_gate_core_o;
    logic [31:0] boot_addr_o;
    logic        lock_timeout_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boot_sleep_ctrl #(
        .LOCK_STABLE_CYCLES  (16),
        .LOCK_TIMEOUT_CYCLES (4096),
        .RST_HOLD_CYCLES     (8),
        .BOOT_ADDR_ROM       (32'h0000_8000),
        .BOOT_ADDR_RAM       (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fll_lock_i      (fll_lock_i),
        .boot_sel_i      (boot_sel_i),
        .fetch_enable_i  (fetch_enable_i),
        .sleep_req_i     (sleep_req_i),
        .core_busy_i     (core_busy_i),
        .irq_pending_i   (irq_pending_i),
        .core_rst_o      (core_rst_o),
        .fetch_enable_o  (fetch_enable_o),
        .clk_gate_core_o (clk_gate_core_o),
        .boot_addr_o     (boot_addr_o),
        .lock_timeout_o  (lock_timeout_o),
        .state_o         (state_o)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic crst,
                              input logic fen, input logic gate);
        check({tag, ".state"}, {29'd0, state_o}, {29'd0, st});
        check({tag, ".core_rst"}, {31'd0, core_rst_o}, {31'd0, crst});
        check({tag, ".fetch"}, {31'd0, fetch_enable_o}, {31'd0, fen});
        check({tag, ".gate"}, {31'd0, clk_gate_core_o}, {31'd0, gate});
    endtask

    initial begin
        // Asynchronous reset values before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b1);
        check("reset.boot_addr", boot_addr_o, 32'h0000_0000);
        check("reset.timeout", {31'd0, lock_timeout_o}, 32'd0);
        tick();
        rst = 1'b0;

        // Lock glitches every 16th cycle: only the timeout can release WAIT_LOCK.
        for (int i = 0; i < 4095; i++) begin
            fll_lock_i = (i % 16 != 15);
            tick();
        end
        check_outs("to.pre", 3'd0, 1'b1, 1'b0, 1'b1);
        check("to.pre.timeout", {31'd0, lock_timeout_o}, 32'd0);
        fll_lock_i = 1'b0;
        tick();
        check_outs("to.enter_hold", 3'd1, 1'b1, 1'b0, 1'b1);
        check("to.timeout", {31'd0, lock_timeout_o}, 32'd1);
        tick(7);
        check_outs("to.hold7", 3'd1, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("to.wait_fetch", 3'd2, 1'b0, 1'b0, 1'b1);
        check("to.boot_ram", boot_addr_o, 32'h0000_0000);
        fetch_enable_i = 1'b1;
        tick();
        check_outs("to.run", 3'd3, 1'b0, 1'b1, 1'b1);
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        check_outs("to.sleep_pend", 3'd4, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("to.sleep", 3'd5, 1'b0, 1'b0, 1'b0);
        check("to.timeout_sticky", {31'd0, lock_timeout_o}, 32'd1);

        // Synchronous-style reset pulse clears the sticky flag.
        rst = 1'b1;
        tick();
        check("rst2.timeout", {31'd0, lock_timeout_o}, 32'd0);
        rst = 1'b0;

        // Normal boot from ROM.
        boot_sel_i = 1'b1;
        fetch_enable_i = 1'b1;
        fll_lock_i = 1'b0;
        tick(10);
        fll_lock_i = 1'b1;
        tick(15);
        check_outs("boot.lock15", 3'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("boot.hold", 3'd1, 1'b1, 1'b0, 1'b1);
        tick(7);
        check_outs("boot.hold7", 3'd1, 1'b1, 1'b0, 1'b1);
        tick();
        check_outs("boot.wait_fetch", 3'd2, 1'b0, 1'b0, 1'b1);
        check("boot.addr_rom", boot_addr_o, 32'h0000_8000);
        tick();
        check_outs("boot.run", 3'd3, 1'b0, 1'b1, 1'b1);
        check("boot.timeout", {31'd0, lock_timeout_o}, 32'd0);
        boot_sel_i = 1'b0;
        fll_lock_i = 1'b0;
        tick();
        check_outs("boot.lock_loss", 3'd3, 1'b0, 1'b1, 1'b1);
        check("boot.addr_held", boot_addr_o, 32'h0000_8000);

        // Sleep request while the core stays busy.
        sleep_req_i = 1'b1;
        core_busy_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        check_outs("busy.pend", 3'd4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs("busy.hold", 3'd4, 1'b0, 1'b0, 1'b1);
        end
        core_busy_i = 1'b0;
        tick();
        check_outs("busy.sleep", 3'd5, 1'b0, 1'b0, 1'b0);
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        check_outs("sleep.req_ignored", 3'd5, 1'b0, 1'b0, 1'b0);

        // Wake back to RUN.
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        check_outs("wake.1", 3'd6, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wake.2", 3'd6, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wake.run", 3'd3, 1'b0, 1'b1, 1'b1);

        // Sleep again, wake with fetch disabled.
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        check_outs("sl2.pend", 3'd4, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("sl2.sleep", 3'd5, 1'b0, 1'b0, 1'b0);
        irq_pending_i = 1'b1;
        fetch_enable_i = 1'b0;
        tick();
        irq_pending_i = 1'b0;
        check_outs("wk2.1", 3'd6, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wk2.2", 3'd6, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("wk2.wait_fetch", 3'd2, 1'b0, 1'b0, 1'b1);
        fetch_enable_i = 1'b1;
        tick();
        check_outs("wk2.run", 3'd3, 1'b0, 1'b1, 1'b1);

        // Fetch deassert beats a coincident sleep request.
        sleep_req_i = 1'b1;
        fetch_enable_i = 1'b0;
        tick();
        sleep_req_i = 1'b0;
        check_outs("prio.fetch_wins", 3'd2, 1'b0, 1'b0, 1'b1);
        // Sleep request outside RUN is dropped, not queued.
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        fetch_enable_i = 1'b1;
        check_outs("drop.wait_fetch", 3'd2, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("drop.run", 3'd3, 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("drop.no_queue", 3'd3, 1'b0, 1'b1, 1'b1);

        // IRQ beats idle core in SLEEP_PEND.
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        check_outs("prio.pend", 3'd4, 1'b0, 1'b0, 1'b1);
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        check_outs("prio.irq_wins", 3'd3, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset while asleep.
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        tick();
        check_outs("ar.sleep", 3'd5, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_outs("ar.async", 3'd0, 1'b1, 1'b0, 1'b1);
        check("ar.boot_addr", boot_addr_o, 32'h0000_0000);
        check("ar.timeout", {31'd0, lock_timeout_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
